// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared state encoding, default device timing and bus widths for the EEPROM sequencer.
package eeprom_pkg;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_WE_PULSE_CYC = 5000;
  localparam int DEF_HOLD_CYC = 2;
  localparam int DEF_WR_CYCLE_CYC = 500000;
  localparam int DEF_RD_ACCESS_CYC = 8;
  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT, RD_SETUP, RD_ACCESS} state_t;
  function automatic int cnt_w(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    m = b > m ? b : m;
    m = c > m ? c : m;
    m = d > m ? d : m;
    m = e > m ? e : m;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/eeprom_bus_ctrl_if.sv
// eeprom_bus_ctrl_if: requester handshakes plus EEPROM pin bundle.
// wr_timeout exists only when EEPROM_DATA_POLL_EN is defined.
interface eeprom_bus_ctrl_if import eeprom_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic wr_req, wr_gnt, wr_done, rd_req, rd_gnt, rd_valid, busy;
  logic ee_doe, ee_ce_n, ee_oe_n, ee_we_n;
  logic [ADDR_W-1:0] wr_addr, rd_addr, ee_addr;
  logic [DATA_W-1:0] wr_data, rd_data, ee_dout, ee_din;
`ifdef EEPROM_DATA_POLL_EN
  logic wr_timeout;
`endif
  modport master (
    input wr_req, wr_addr, wr_data, rd_req, rd_addr, ee_din,
    output wr_gnt, wr_done, rd_gnt, rd_valid, rd_data, busy,
    output ee_addr, ee_dout, ee_doe, ee_ce_n, ee_oe_n, ee_we_n
`ifdef EEPROM_DATA_POLL_EN
    , output wr_timeout
`endif
  );
  modport slave (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ee_din,
    input wr_gnt, wr_done, rd_gnt, rd_valid, rd_data, busy,
    input ee_addr, ee_dout, ee_doe, ee_ce_n, ee_oe_n, ee_we_n
`ifdef EEPROM_DATA_POLL_EN
    , input wr_timeout
`endif
  );
endinterface

// File: rtl/eeprom_timer.sv
// eeprom_timer: loadable down-counter that parks at zero; zero flags the last cycle of a timed state.
module eeprom_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - W'(1) : cnt);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/eeprom_bus_ctrl.sv
// eeprom_bus_ctrl: round-robin sequencer for the parallel EEPROM; EEPROM_DATA_POLL_EN
// swaps the fixed write-recovery wait for DQ7 data polling with timeout.
module eeprom_bus_ctrl import eeprom_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int WE_PULSE_CYC = DEF_WE_PULSE_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int WR_CYCLE_CYC = DEF_WR_CYCLE_CYC,
  parameter int RD_ACCESS_CYC = DEF_RD_ACCESS_CYC
) (
  input logic clk,
  input logic reset,
  eeprom_bus_ctrl_if.master bus
);
  localparam int CW = cnt_w(SETUP_CYC, WE_PULSE_CYC, HOLD_CYC, WR_CYCLE_CYC, RD_ACCESS_CYC);
  state_t state, state_n;
  logic [CW-1:0] load_val;
  logic load, zero, last_wr, pick_wr, gnt_w, gnt_r, done_w, valid_w, wr_drive, wait_lo;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  eeprom_timer #(.W(CW)) u_timer (.clk(clk), .reset(reset), .load(load), .load_val(load_val), .zero(zero));
`ifdef EEPROM_DATA_POLL_EN
  logic [1:0] ph;
  logic tmo, poll_hit;
  // Two-cycle OE pulse every four cycles; DQ7 is judged on the second low cycle.
  assign wait_lo = state == WR_WAIT && !ph[1];
  assign poll_hit = state == WR_WAIT && ph == 2'd1 && bus.ee_din[DATA_W-1] == dout_q[DATA_W-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      ph <= '0;
      bus.wr_timeout <= 1'b0;
    end else begin
      ph <= state == WR_WAIT ? ph + 2'd1 : 2'd0;
      bus.wr_timeout <= tmo;
    end
  end
`else
  assign wait_lo = 1'b0;
`endif
  // The side not served last wins a tie; last_wr=0 after reset gives the writer first turn.
  assign pick_wr = bus.wr_req && (!bus.rd_req || !last_wr);
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_val = '0;
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    done_w = 1'b0;
    valid_w = 1'b0;
`ifdef EEPROM_DATA_POLL_EN
    tmo = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_wr) begin
          state_n = WR_SETUP;
          load = 1'b1;
          load_val = CW'(SETUP_CYC - 1);
          gnt_w = 1'b1;
        end else if (bus.rd_req) begin
          state_n = RD_SETUP;
          load = 1'b1;
          load_val = CW'(SETUP_CYC - 1);
          gnt_r = 1'b1;
        end
      end
      WR_SETUP: if (zero) begin
        state_n = WR_PULSE;
        load = 1'b1;
        load_val = CW'(WE_PULSE_CYC - 1);
      end
      WR_PULSE: if (zero) begin
        state_n = WR_HOLD;
        load = 1'b1;
        load_val = CW'(HOLD_CYC - 1);
      end
      WR_HOLD: if (zero) begin
        state_n = WR_WAIT;
        load = 1'b1;
        load_val = CW'(WR_CYCLE_CYC - 1);
      end
`ifdef EEPROM_DATA_POLL_EN
      WR_WAIT: if (poll_hit || zero) begin
        state_n = IDLE;
        done_w = 1'b1;
        tmo = !poll_hit;
      end
`else
      WR_WAIT: if (zero) begin
        state_n = IDLE;
        done_w = 1'b1;
      end
`endif
      RD_SETUP: if (zero) begin
        state_n = RD_ACCESS;
        load = 1'b1;
        load_val = CW'(RD_ACCESS_CYC - 1);
      end
      RD_ACCESS: if (zero) begin
        state_n = IDLE;
        valid_w = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_wr <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      bus.rd_data <= '0;
      bus.wr_gnt <= 1'b0;
      bus.rd_gnt <= 1'b0;
      bus.wr_done <= 1'b0;
      bus.rd_valid <= 1'b0;
    end else begin
      state <= state_n;
      bus.wr_gnt <= gnt_w;
      bus.rd_gnt <= gnt_r;
      bus.wr_done <= done_w;
      bus.rd_valid <= valid_w;
      if (gnt_w) begin
        last_wr <= 1'b1;
        addr_q <= bus.wr_addr;
        dout_q <= bus.wr_data;
      end
      if (gnt_r) begin
        last_wr <= 1'b0;
        addr_q <= bus.rd_addr;
      end
      if (valid_w) bus.rd_data <= bus.ee_din;
    end
  end
  assign wr_drive = state == WR_SETUP || state == WR_PULSE || state == WR_HOLD;
  assign bus.busy = state != IDLE;
  assign bus.ee_addr = addr_q;
  assign bus.ee_dout = dout_q;
  assign bus.ee_doe = wr_drive;
  assign bus.ee_we_n = state != WR_PULSE;
  assign bus.ee_oe_n = !(state == RD_ACCESS || wait_lo);
  assign bus.ee_ce_n = !(wr_drive || state == RD_SETUP || state == RD_ACCESS || wait_lo);
endmodule

// File: tb/tb_eeprom_bus_ctrl.sv
// tb_eeprom_bus_ctrl: directed checks of the EEPROM sequencer with short timing parameters.
// Covers the EEPROM_DATA_POLL_EN build when that macro is defined.
module tb_eeprom_bus_ctrl;
  localparam int S = 2, P = 5, H = 2, W = 20, R = 8;
  localparam int WR_LAT = S + P + H + W;
  localparam int RD_LAT = S + R;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic poll_mode = 1'b0;
  logic flip = 1'b0;
  logic wbit = 1'b0;
  int since_we = 0;
  int viol = 0;
  int errors = 0;
  int checks = 0;
  eeprom_bus_ctrl_if bus();
  eeprom_bus_ctrl #(
    .SETUP_CYC(S), .WE_PULSE_CYC(P), .HOLD_CYC(H), .WR_CYCLE_CYC(W), .RD_ACCESS_CYC(R)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // Device model: plain reads return a function of the address; polling returns DQ7 only.
  always_comb begin
    if (bus.ee_oe_n) bus.ee_din = 8'hFF;
    else if (poll_mode) bus.ee_din = {(flip && since_we >= 12) ? wbit : ~wbit, 7'h00};
    else bus.ee_din = bus.ee_addr == 13'h1FFF ? 8'h3C : bus.ee_addr[7:0] ^ 8'h5A;
  end
  always @(posedge clk) begin
    if (!bus.ee_we_n) begin
      since_we <= 0;
      wbit <= bus.ee_dout[7];
    end else if (since_we < 1000) since_we <= since_we + 1;
  end
  always @(negedge clk) begin
    if (!reset && ((!bus.ee_we_n && !bus.ee_oe_n) || (bus.ee_doe && !bus.ee_oe_n) || (bus.ee_doe && bus.ee_ce_n)))
      viol++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [12:0] a, input logic [7:0] d,
                          output int done_n, output int we_cnt, output int doe_cnt, output int bad, output int tmo);
    int k;
    done_n = -1; we_cnt = 0; doe_cnt = 0; bad = 0; tmo = 0;
    bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
    for (k = 0; k < 20 && !bus.wr_gnt; k++) tick;
    bus.wr_req = 1'b0;
    if (!bus.wr_gnt) begin
      chk("wr_gnt_wait", 0, 1);
      return;
    end
    for (int n = 0; n < WR_LAT + 10; n++) begin
      if (!bus.ee_we_n) we_cnt++;
      if (bus.ee_doe) begin
        doe_cnt++;
        if (bus.ee_dout !== d || bus.ee_addr !== a) bad++;
      end
      if (bus.wr_done) begin
        done_n = n;
`ifdef EEPROM_DATA_POLL_EN
        tmo = int'(bus.wr_timeout);
`endif
        break;
      end
      tick;
    end
  endtask
  task automatic do_read(input logic [12:0] a, output int valid_n, output int oe_cnt, output int doe_seen);
    int k;
    valid_n = -1; oe_cnt = 0; doe_seen = 0;
    bus.rd_addr = a; bus.rd_req = 1'b1;
    for (k = 0; k < 20 && !bus.rd_gnt; k++) tick;
    bus.rd_req = 1'b0;
    if (!bus.rd_gnt) begin
      chk("rd_gnt_wait", 0, 1);
      return;
    end
    for (int n = 0; n < RD_LAT + 10; n++) begin
      if (!bus.ee_oe_n) oe_cnt++;
      if (bus.ee_doe) doe_seen++;
      if (bus.rd_valid) begin
        valid_n = n;
        break;
      end
      tick;
    end
  endtask
  initial begin
    int done_n, we_cnt, doe_cnt, bad, tmo, valid_n, oe_cnt, doe_seen;
    int grants, overlap, gap_bad, last_end, outstanding, seen_done, k;
    int unsigned r;
    logic [3:0] order;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    tick; tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_ce_n", bus.ee_ce_n, 1);
    chk("rst_oe_n", bus.ee_oe_n, 1);
    chk("rst_we_n", bus.ee_we_n, 1);
    chk("rst_doe", bus.ee_doe, 0);
    chk("rst_addr", bus.ee_addr, 0);
    chk("rst_dout", bus.ee_dout, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_pulses", {bus.wr_gnt, bus.rd_gnt, bus.wr_done, bus.rd_valid}, 0);
    reset = 1'b0;
    tick;
    do_write(13'h0005, 8'hA5, done_n, we_cnt, doe_cnt, bad, tmo);
    chk("wr_latency", done_n, WR_LAT);
    chk("wr_we_low_cycles", we_cnt, P);
    chk("wr_doe_cycles", doe_cnt, S + P + H);
    chk("wr_addr_data_stable", bad, 0);
`ifdef EEPROM_DATA_POLL_EN
    chk("wr_poll_no_match_timeout", tmo, 1);
`endif
    tick;
    do_read(13'h1FFF, valid_n, oe_cnt, doe_seen);
    chk("rd_latency", valid_n, RD_LAT);
    chk("rd_oe_low_cycles", oe_cnt, R);
    chk("rd_doe_low", doe_seen, 0);
    chk("rd_data", bus.rd_data, 8'h3C);
    tick; tick; tick;
    chk("rd_data_held", bus.rd_data, 8'h3C);
    chk("rd_idle_strobes", {bus.ee_ce_n, bus.ee_oe_n, bus.busy}, 3'b110);
    // Both sides requesting continuously from reset: expect W,R,W,R with one idle cycle between.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.wr_addr = 13'h0100; bus.wr_data = 8'h11; bus.rd_addr = 13'h0012;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    grants = 0; overlap = 0; gap_bad = 0; last_end = -1; outstanding = 0; order = '0;
    for (int c = 0; c < 400; c++) begin
      tick;
      if (bus.wr_done || bus.rd_valid) begin
        outstanding = 0;
        last_end = c;
      end
      if (bus.wr_gnt || bus.rd_gnt) begin
        if (outstanding != 0 || (bus.wr_gnt && bus.rd_gnt)) overlap++;
        if (grants > 0 && c - last_end != 1) gap_bad++;
        order = {order[2:0], bus.wr_gnt};
        outstanding = 1;
        grants++;
        if (grants == 4) begin
          bus.wr_req = 1'b0;
          bus.rd_req = 1'b0;
        end
      end
      if (grants == 4 && outstanding == 0) break;
    end
    chk("rr_grants", grants, 4);
    chk("rr_order", order, 4'b1010);
    chk("rr_overlap", overlap, 0);
    chk("rr_one_idle_gap", gap_bad, 0);
    chk("rr_rd_data", bus.rd_data, 8'h48);
    // Reset in the middle of the write pulse drops the write silently.
    tick;
    bus.wr_addr = 13'h0AAA; bus.wr_data = 8'h55; bus.wr_req = 1'b1;
    for (k = 0; k < 20 && !bus.wr_gnt; k++) tick;
    bus.wr_req = 1'b0;
    for (k = 0; k < 20 && bus.ee_we_n; k++) tick;
    chk("mid_we_low_seen", bus.ee_we_n, 0);
    tick; tick;
    reset = 1'b1;
    tick;
    chk("mid_rst_we_n", bus.ee_we_n, 1);
    chk("mid_rst_ce_n", bus.ee_ce_n, 1);
    chk("mid_rst_doe", bus.ee_doe, 0);
    chk("mid_rst_busy", bus.busy, 0);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < WR_LAT + 20; c++) begin
      tick;
      if (bus.wr_done) seen_done++;
    end
    chk("mid_rst_no_done", seen_done, 0);
    // Random traffic while the negedge monitor watches the strobe invariants.
    k = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!bus.wr_req && !bus.rd_req) begin
        r = $urandom_range(1, 3);
        bus.wr_addr = 13'($urandom); bus.wr_data = 8'($urandom); bus.rd_addr = 13'($urandom);
        bus.wr_req = r[0]; bus.rd_req = r[1];
      end
      for (k = 0; k < 100 && !bus.wr_gnt && !bus.rd_gnt; k++) tick;
      if (bus.wr_gnt) bus.wr_req = 1'b0;
      if (bus.rd_gnt) bus.rd_req = 1'b0;
      if (k == 100) begin
        chk("rand_gnt_wait", 0, 1);
        break;
      end
      tick;
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    for (k = 0; k < 100 && bus.busy; k++) tick;
    chk("rand_idle", bus.busy, 0);
    chk("strobe_invariants", viol, 0);
`ifdef EEPROM_DATA_POLL_EN
    tick;
    poll_mode = 1'b1; flip = 1'b1;
    do_write(13'h0020, 8'h80, done_n, we_cnt, doe_cnt, bad, tmo);
    chk("poll_early_done", done_n > 0 && done_n < WR_LAT, 1);
    chk("poll_early_no_timeout", tmo, 0);
    tick;
    flip = 1'b0;
    do_write(13'h0021, 8'h80, done_n, we_cnt, doe_cnt, bad, tmo);
    chk("poll_timeout_latency", done_n, WR_LAT);
    chk("poll_timeout_flag", tmo, 1);
    poll_mode = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/eeprom_bus_ctrl.md
Name: eeprom_bus_ctrl

Overview:
- Sequencer and arbiter for the board's parallel 8K x 8 EEPROM bus (13-bit address, 8-bit data, active-low CE/OE/WE).
- Two requesters share the device:
  - a write/programming requester (bulk loader from on-chip data memory);
  - a read requester (CPU instruction/data fetch).
- Generates all device timing: address/data setup, write-pulse width, write-cycle recovery, read access. Arbitrates round-robin between requesters.

Parameters:
- ADDR_W, 13, EEPROM address width
- DATA_W, 8, EEPROM data width
- SETUP_CYC, 2, cycles address/data held stable before strobe
- WE_PULSE_CYC, 5000, cycles ee_we_n held low
- HOLD_CYC, 2, cycles address/data held after strobe deasserts
- WR_CYCLE_CYC, 500000, internal write-cycle recovery after a write (10 ms at 50 MHz)
- RD_ACCESS_CYC, 8, cycles from ee_oe_n low to data capture
- All timing parameters must be ≥1. Counter width = clog2 of the largest timing parameter, plus 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_req  in  1  write request; held until wr_gnt
- wr_addr  in  ADDR_W  write address; sampled at grant
- wr_data  in  DATA_W  write data; sampled at grant
- wr_gnt  out  1  1-cycle pulse: write accepted
- wr_done  out  1  1-cycle pulse: write cycle complete, device ready
- rd_req  in  1  read request; held until rd_gnt
- rd_addr  in  ADDR_W  read address; sampled at grant
- rd_gnt  out  1  1-cycle pulse: read accepted
- rd_valid  out  1  1-cycle pulse: rd_data valid
- rd_data  out  DATA_W  captured read data; held until next capture
- busy  out  1  high whenever state != IDLE
- ee_addr  out  ADDR_W  device address
- ee_dout  out  DATA_W  device write data
- ee_doe  out  1  data-bus drive enable (1 = FPGA drives DQ)
- ee_din  in  DATA_W  device read data
- ee_ce_n, ee_oe_n, ee_we_n  out  1 each  device strobes, active low

Behaviour:
- Reset (one clk edge with reset=1):
  - state=IDLE, all counters 0.
  - ee_ce_n=ee_oe_n=ee_we_n=1, ee_doe=0, ee_addr=0, ee_dout=0.
  - rd_data=0; all gnt/done/valid pulses 0; busy=0; round-robin pointer = write-first.
- Reset mid-operation: same as above on the next edge. The in-flight transaction is dropped; no done/valid pulse is issued.
- Arbitration, IDLE only:
  - Single requester: granted.
  - Both requesting: the side not served last wins. After reset the write side wins first.
  - Grant pulse and address/data capture happen on the same edge as the IDLE exit.
  - A request is ignored while busy.
- Write path, states WR_SETUP → WR_PULSE → WR_HOLD → WR_WAIT → IDLE:
  - WR_SETUP, SETUP_CYC cycles: ee_ce_n=0, ee_doe=1, ee_addr/ee_dout driven, ee_we_n=1, ee_oe_n=1.
  - WR_PULSE, WE_PULSE_CYC cycles: ee_we_n=0.
  - WR_HOLD, HOLD_CYC cycles: ee_we_n=1, address/data still driven.
  - WR_WAIT: ee_ce_n=1, ee_doe=0, for WR_CYCLE_CYC cycles.
  - wr_done pulses on the exit edge to IDLE.
  - Total write latency, gnt to done = SETUP_CYC+WE_PULSE_CYC+HOLD_CYC+WR_CYCLE_CYC cycles.
- Read path, states RD_SETUP → RD_ACCESS → IDLE:
  - ee_doe=0 throughout.
  - RD_SETUP, SETUP_CYC cycles: ee_ce_n=0, ee_addr driven.
  - RD_ACCESS, RD_ACCESS_CYC cycles: ee_oe_n=0.
  - On the last RD_ACCESS cycle: rd_data <= ee_din, rd_valid pulses, ee_oe_n/ee_ce_n return to 1 on the next edge.
  - Read latency, gnt to valid = SETUP_CYC+RD_ACCESS_CYC cycles.
- Invariants:
  - ee_we_n and ee_oe_n are never low simultaneously.
  - ee_doe=1 only in WR_SETUP/WR_PULSE/WR_HOLD.
- Back-to-back operation: a new grant can occur on the cycle after done/valid (one IDLE cycle minimum).
- Address wrap is not handled by this block; the requester supplies every address.

Optional Feature:
- Macro: EEPROM_DATA_POLL_EN.
- When defined, WR_WAIT performs DATA-polling instead of a fixed delay:
  - Every 4 cycles, pulse ee_ce_n/ee_oe_n low for 2 cycles and sample ee_din[7].
  - Exit when ee_din[7] equals the written data bit 7.
  - WR_CYCLE_CYC acts as a timeout. On timeout, wr_done pulses and an extra output wr_timeout (1 bit, 1-cycle pulse) pulses alongside it.
- When undefined: fixed WR_CYCLE_CYC wait; wr_timeout port absent.

Decomposition:
- Shared package eeprom_pkg:
  - state enum (IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT, RD_SETUP, RD_ACCESS);
  - default timing constants;
  - ADDR_W/DATA_W defaults.
- One sub-module, eeprom_timer: loadable down-counter with load value input, load strobe, and a zero flag. It is shared by all states.

Test Plan:
- Single write: wr_req, addr=0x0005, data=0xA5, SETUP=2/PULSE=5/HOLD=2/WRCYC=20 → ee_we_n low exactly 5 cycles; ee_dout=0xA5 stable from setup start through hold; wr_done 29 cycles after wr_gnt.
- Single read: rd_addr=0x1FFF, ee_din model returns 0x3C, RD_ACCESS=8 → rd_valid 10 cycles after rd_gnt, rd_data=0x3C; ee_doe stays 0.
- Simultaneous wr_req and rd_req held continuously after reset → grant order W,R,W,R; no overlap of busy transactions.
- Assert reset during WR_PULSE → next edge: ee_we_n=1, ee_ce_n=1, ee_doe=0, busy=0; no wr_done ever issued for that write.
- Strobe invariant checker over 1000 random requests → never ee_we_n=0 with ee_oe_n=0; never ee_doe=1 with ee_oe_n=0.
- With EEPROM_DATA_POLL_EN: device model flips DQ7 to true data after 12 cycles → wr_done before WRCYC expires, wr_timeout=0. A model that never flips → wr_done and wr_timeout both pulse at the timeout.
